// File: rtl/arbitro_mem_relacoes_pkg.sv
// arbitro_pkg: shared constants and pipe-entry type for the relations-memory arbiter
package arbitro_pkg;
    localparam int NUM_NA_CFG = 8;
    localparam int ID_WIDTH   = $clog2(NUM_NA_CFG);
    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
    } pipe_ent_t;
endpackage

// File: rtl/arbitro_mem_relacoes_rr.sv
// rr_prioridade: rotating priority encoder, scanning from i_ptr upward with wrap
module rr_prioridade
    import arbitro_pkg::*;
#(
    parameter int NUM_NA = NUM_NA_CFG
)(
    input  logic [NUM_NA-1:0]   i_elig,
    input  logic [ID_WIDTH-1:0] i_ptr,
    output logic [NUM_NA-1:0]   o_gnt,
    output logic [ID_WIDTH-1:0] o_id,
    output logic                o_found
);
    logic [ID_WIDTH:0] w_sum;
    always_comb begin
        o_gnt   = '0;
        o_id    = '0;
        o_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < NUM_NA; k++) begin
            w_sum = {1'b0, i_ptr} + (ID_WIDTH+1)'(k);
            w_sum = (w_sum >= (ID_WIDTH+1)'(NUM_NA)) ? w_sum - (ID_WIDTH+1)'(NUM_NA) : w_sum;
            if (!o_found && i_elig[w_sum[ID_WIDTH-1:0]]) begin
                o_gnt[w_sum[ID_WIDTH-1:0]] = 1'b1;
                o_id    = w_sum[ID_WIDTH-1:0];
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/arbitro_mem_relacoes.sv
// arbitro_mem_relacoes: round-robin arbiter sharing the relations-memory read port
module arbitro_mem_relacoes
    import arbitro_pkg::*;
#(
    parameter int NUM_NA              = NUM_NA_CFG,
    parameter int ADDR_WIDTH          = 10,
    parameter int RELACOES_DATA_WIDTH = 104,
    parameter int MEM_LATENCY         = 1
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_in,
    input  logic                           ext_busy_in,
    input  logic [NUM_NA-1:0]              na_req_in,
    input  logic [NUM_NA*ADDR_WIDTH-1:0]   na_addr_in,
    output logic [NUM_NA-1:0]              na_gnt_out,
    output logic [NUM_NA-1:0]              na_rvalid_out,
    output logic [RELACOES_DATA_WIDTH-1:0] na_rdata_out,
    output logic                           mem_rd_en_out,
    output logic [ADDR_WIDTH-1:0]          mem_addr_out,
    input  logic [RELACOES_DATA_WIDTH-1:0] mem_rdata_in,
    output logic                           idle_out
);
    logic [NUM_NA-1:0]     r_pending, w_elig, w_gnt_raw, w_ret_oh;
    logic [ID_WIDTH-1:0]   r_ptr, w_id;
    logic                  w_found, w_any, r_rd_en, r_idle;
    logic [ADDR_WIDTH-1:0] r_addr;
    pipe_ent_t             r_iss, w_ret;
    pipe_ent_t             r_pipe [MEM_LATENCY];

    assign w_elig = na_req_in & ~r_pending;

    rr_prioridade #(.NUM_NA(NUM_NA)) u_rr (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt_raw),
        .o_id    (w_id),
        .o_found (w_found)
    );

    assign w_any         = w_found & ~rst & ~flush_in & ~ext_busy_in;
    assign na_gnt_out    = w_any ? w_gnt_raw : '0;
    assign w_ret         = r_pipe[MEM_LATENCY-1];
    // a same-cycle flush kills the return strobe as well as the grant
    assign w_ret_oh      = (w_ret.valid && !flush_in && !rst) ? (NUM_NA'(1) << w_ret.id) : '0;
    assign na_rvalid_out = w_ret_oh;
    assign na_rdata_out  = mem_rdata_in;
    assign mem_rd_en_out = r_rd_en;
    assign mem_addr_out  = r_addr;
    assign idle_out      = r_idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_pending <= '0;
            r_rd_en   <= 1'b0;
            r_addr    <= '0;
            r_idle    <= 1'b1;
            r_iss     <= '0;
            for (int k = 0; k < MEM_LATENCY; k++) r_pipe[k] <= '0;
        end else begin
            r_rd_en <= w_any;
            r_addr  <= w_any ? na_addr_in[w_id*ADDR_WIDTH +: ADDR_WIDTH] : r_addr;
            r_idle  <= (r_pending == '0) && (na_req_in == '0);
            r_iss   <= '{valid: w_any, id: w_id};
            if (flush_in) begin
                r_ptr     <= '0;
                r_pending <= '0;
                for (int k = 0; k < MEM_LATENCY; k++) r_pipe[k] <= '0;
            end else begin
                r_ptr     <= !w_any ? r_ptr : (w_id == ID_WIDTH'(NUM_NA-1)) ? '0 : w_id + 1'b1;
                r_pending <= (r_pending | na_gnt_out) & ~w_ret_oh;
                r_pipe[0] <= r_iss;
                for (int k = 1; k < MEM_LATENCY; k++) r_pipe[k] <= r_pipe[k-1];
            end
        end
    end
endmodule

// File: tb/tb_arbitro_mem_relacoes.sv
// tb_arbitro_mem_relacoes: directed self-checking bench for the relations-memory arbiter
module tb_arbitro_mem_relacoes;
    localparam int N = 8, AW = 10, DW = 104, L = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1, flush_in = 1'b0, ext_busy_in = 1'b0;
    logic [N-1:0]  na_req_in = '0, na_gnt_out, na_rvalid_out;
    logic [N*AW-1:0] na_addr_in = '0;
    logic [DW-1:0] na_rdata_out, mem_rdata_in = '0;
    logic          mem_rd_en_out, idle_out;
    logic [AW-1:0] mem_addr_out;
    int            n_tests = 0, n_fail = 0;

    arbitro_mem_relacoes #(.NUM_NA(N), .ADDR_WIDTH(AW), .RELACOES_DATA_WIDTH(DW), .MEM_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .flush_in(flush_in), .ext_busy_in(ext_busy_in),
        .na_req_in(na_req_in), .na_addr_in(na_addr_in), .na_gnt_out(na_gnt_out),
        .na_rvalid_out(na_rvalid_out), .na_rdata_out(na_rdata_out),
        .mem_rd_en_out(mem_rd_en_out), .mem_addr_out(mem_addr_out),
        .mem_rdata_in(mem_rdata_in), .idle_out(idle_out)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
        return {8{3'b101, a}};
    endfunction

    // one-cycle-latency memory model
    always @(posedge clk) if (mem_rd_en_out) mem_rdata_in <= f(mem_addr_out);

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] eg, ev;
        for (int i = 0; i < N; i++) na_addr_in[i*AW +: AW] = AW'(100 + i);
        // reset, with requests pending
        @(negedge clk); na_req_in = 8'hFF; #1;
        chk("rst_gnt", 128'(na_gnt_out), 128'(0));
        chk("rst_rvalid", 128'(na_rvalid_out), 128'(0));
        chk("rst_rden", 128'(mem_rd_en_out), 128'(0));
        chk("rst_addr", 128'(mem_addr_out), 128'(0));
        chk("rst_idle", 128'(idle_out), 128'(1));
        @(negedge clk); rst = 1'b0; na_req_in = '0;
        // 1: single request
        @(negedge clk); na_req_in = 8'h08; na_addr_in[3*AW +: AW] = 10'd12; #1;
        chk("t1_gnt", 128'(na_gnt_out), 128'(8'h08));
        @(negedge clk); na_req_in = '0; #1;
        chk("t1_gnt_off", 128'(na_gnt_out), 128'(0));
        chk("t1_rden", 128'(mem_rd_en_out), 128'(1));
        chk("t1_addr", 128'(mem_addr_out), 128'(12));
        chk("t1_rvalid_early", 128'(na_rvalid_out), 128'(0));
        @(negedge clk); #1;
        chk("t1_rvalid", 128'(na_rvalid_out), 128'(8'h08));
        chk("t1_rdata", 128'(na_rdata_out), 128'(f(10'd12)));
        chk("t1_rden_off", 128'(mem_rd_en_out), 128'(0));
        @(negedge clk); #1;
        chk("t1_rvalid_off", 128'(na_rvalid_out), 128'(0));
        @(negedge clk); #1;
        chk("t1_idle", 128'(idle_out), 128'(1));
        na_addr_in[3*AW +: AW] = 10'd103;
        // flush resets ptr (was 4) and never grants
        @(negedge clk); flush_in = 1'b1; na_req_in = 8'hFF; #1;
        chk("fl_gnt", 128'(na_gnt_out), 128'(0));
        // 2: all requesters, back to back
        for (int k = 0; k < 11; k++) begin
            @(negedge clk); flush_in = 1'b0; na_req_in = (k < 9) ? 8'hFF : 8'h00; #1;
            eg = (k < 8) ? (8'(1) << k) : (k == 8) ? 8'h01 : 8'h00;
            ev = (k >= 2) ? (8'(1) << ((k - 2) % 8)) : 8'h00;
            chk($sformatf("t2_gnt%0d", k), 128'(na_gnt_out), 128'(eg));
            chk($sformatf("t2_rden%0d", k), 128'(mem_rd_en_out), 128'(k >= 1 && k <= 9));
            if (k >= 1 && k <= 9) chk($sformatf("t2_addr%0d", k), 128'(mem_addr_out), 128'(100 + (k - 1) % 8));
            chk($sformatf("t2_rvalid%0d", k), 128'(na_rvalid_out), 128'(ev));
            if (k >= 2) chk($sformatf("t2_rdata%0d", k), 128'(na_rdata_out), 128'(f(AW'(100 + (k - 2) % 8))));
        end
        // single requester holding req: regrant at T+3
        @(negedge clk); na_req_in = 8'h01; #1;
        chk("rg_t0", 128'(na_gnt_out), 128'(8'h01));
        @(negedge clk); #1;
        chk("rg_t1", 128'(na_gnt_out), 128'(0));
        @(negedge clk); #1;
        chk("rg_t2_gnt", 128'(na_gnt_out), 128'(0));
        chk("rg_t2_rvalid", 128'(na_rvalid_out), 128'(8'h01));
        @(negedge clk); #1;
        chk("rg_t3", 128'(na_gnt_out), 128'(8'h01));
        @(negedge clk); na_req_in = '0; idle_cycles(2);
        // 3: move ptr to 3 via requester 2, then 2 and 5 compete
        @(negedge clk); na_req_in = 8'h04; #1;
        chk("t3_pre", 128'(na_gnt_out), 128'(8'h04));
        @(negedge clk); na_req_in = '0; idle_cycles(2);
        @(negedge clk); na_req_in = 8'h24; #1;
        chk("t3_first", 128'(na_gnt_out), 128'(8'h20));
        @(negedge clk); #1;
        chk("t3_second", 128'(na_gnt_out), 128'(8'h04));
        @(negedge clk); na_req_in = '0; idle_cycles(2);
        @(negedge clk); na_req_in = 8'h09; #1;
        chk("t3_ptr3", 128'(na_gnt_out), 128'(8'h08));
        @(negedge clk); na_req_in = '0; idle_cycles(2);
        // 4: stall
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); ext_busy_in = 1'b1; na_req_in = 8'h02; #1;
            chk($sformatf("t4_busy%0d", k), 128'(na_gnt_out), 128'(0));
        end
        @(negedge clk); ext_busy_in = 1'b0; #1;
        chk("t4_gnt", 128'(na_gnt_out), 128'(8'h02));
        @(negedge clk); ext_busy_in = 1'b1; na_req_in = '0; #1;
        chk("t4_rden", 128'(mem_rd_en_out), 128'(1));
        chk("t4_addr", 128'(mem_addr_out), 128'(101));
        @(negedge clk); #1;
        chk("t4_rvalid", 128'(na_rvalid_out), 128'(8'h02));
        chk("t4_rdata", 128'(na_rdata_out), 128'(f(10'd101)));
        @(negedge clk); ext_busy_in = 1'b0;
        // 5: flush kills an in-flight read
        @(negedge clk); na_req_in = 8'h40; #1;
        chk("t5_gnt", 128'(na_gnt_out), 128'(8'h40));
        @(negedge clk); flush_in = 1'b1; #1;
        chk("t5_flush_gnt", 128'(na_gnt_out), 128'(0));
        chk("t5_flush_rden", 128'(mem_rd_en_out), 128'(1));
        @(negedge clk); flush_in = 1'b0; #1;
        chk("t5_no_rvalid", 128'(na_rvalid_out), 128'(0));
        chk("t5_regrant", 128'(na_gnt_out), 128'(8'h40));
        @(negedge clk); #1;
        chk("t5_pending", 128'(na_gnt_out), 128'(0));
        @(negedge clk); flush_in = 1'b1; na_req_in = '0; #1;
        chk("t5_flush_ret", 128'(na_rvalid_out), 128'(0));
        @(negedge clk); flush_in = 1'b0; #1;
        chk("t5_after_ret", 128'(na_rvalid_out), 128'(0));
        chk("t5_idle0", 128'(idle_out), 128'(0));
        @(negedge clk); #1;
        chk("t5_idle1", 128'(idle_out), 128'(1));
        // 6: async reset mid-operation
        @(negedge clk); na_req_in = 8'h10; #1;
        chk("t6_gnt", 128'(na_gnt_out), 128'(8'h10));
        @(negedge clk); #1;
        chk("t6_rden_pre", 128'(mem_rd_en_out), 128'(1));
        rst = 1'b1; na_req_in = '0; #1;
        chk("t6_rden", 128'(mem_rd_en_out), 128'(0));
        chk("t6_addr", 128'(mem_addr_out), 128'(0));
        chk("t6_idle", 128'(idle_out), 128'(1));
        chk("t6_gnt_rst", 128'(na_gnt_out), 128'(0));
        @(negedge clk); rst = 1'b0; #1;
        chk("t6_rvalid0", 128'(na_rvalid_out), 128'(0));
        @(negedge clk); #1;
        chk("t6_rvalid1", 128'(na_rvalid_out), 128'(0));
        chk("t6_idle_end", 128'(idle_out), 128'(1));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
